voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
Sits between song_reader's event stream and the NUM_VOICES note players. Consumes note/advance events over a valid/ready handshake and assigns each note to the lowest-index idle voice. Holds the stream for advance events by counting beats. Tracks per-voice busy state from the note players' done pulses, and stalls the stream when every voice is busy.

Parameters:
NUM_VOICES, 3, number of note players sharing the stream
NOTE_W, 6, note code width
DUR_W, 6, duration width in beats

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  play/pause; 0 freezes scheduling and beat counting
flush  in  1  synchronous clear of scheduler state (song change)
beat  in  1  one-cycle beat strobe
evt_valid  in  1  event available
evt_ready  out  1  event consumed this cycle when valid&ready
evt_is_advance  in  1  1 = advance/rest entry, 0 = note
evt_note  in  NOTE_W  note code (ignored for advance)
evt_duration  in  DUR_W  note length or advance wait, in beats
voice_done  in  NUM_VOICES  per-voice done pulse from note player
voice_load  out  NUM_VOICES  one-cycle load strobe per voice
voice_note  out  NUM_VOICES*NOTE_W  per-voice note, voice i at [i*NOTE_W +: NOTE_W]
voice_duration  out  NUM_VOICES*DUR_W  per-voice duration, same packing
voice_busy  out  NUM_VOICES  registered busy mask
all_busy  out  1  combinational AND of voice_busy
advancing  out  1  high while in WAIT_ADV
adv_remaining  out  DUR_W  beats left in current advance

Behaviour:
- Reset (reset=0, async) drives every output register to 0: voice_load, voice_note, voice_duration, voice_busy, adv_remaining. State goes to RUN.
- FSM states:
  - RUN: accepting events.
  - WAIT_ADV: counting down an advance.
- evt_ready is combinational and equals enable & !flush & state==RUN & (evt_is_advance | !all_busy). It must not depend on evt_valid.
- Note handshake in RUN with duration != 0:
  - sel = lowest index i with voice_busy[i]=0, taken from registered busy.
  - At the handshake edge: voice_busy[sel]<=1, voice_note/voice_duration slot sel<=event fields, voice_load[sel]<=1 for exactly one cycle.
  - Latency: handshake cycle N, load visible in cycle N+1.
- Note with duration 0: consumed, no voice allocated, no load.
- Advance handshake in RUN:
  - duration 0: consumed, stay in RUN.
  - otherwise: adv_remaining<=duration, go to WAIT_ADV.
- WAIT_ADV:
  - Each cycle with beat&enable decrements adv_remaining.
  - A beat with adv_remaining==1 sets it to 0 and returns to RUN; evt_ready can assert the following cycle.
  - evt_ready stays 0 throughout.
- voice_done[i] clears voice_busy[i] at the edge. Because selection uses registered busy, a voice freed in cycle N is selectable in N+1. A done and a load never target the same voice in the same cycle.
- voice_done on a voice that is not busy: ignored.
- enable=0:
  - evt_ready=0 and beats are ignored; the adv_remaining and busy masks hold.
  - voice_done is still honoured, so note players may finish.
- flush=1 (synchronous):
  - voice_busy<=0, adv_remaining<=0, state<=RUN, voice_load<=0, evt_ready=0 that cycle.
  - flush overrides voice_done and beat in the same cycle.
- all_busy in RUN with a pending note event: stall; the event is held by the producer, with no drop.
- Reset asserted mid-advance or mid-load: immediate return to reset values; no partial load pulse survives.
- Counter width is DUR_W; the decrement never wraps because 0 is only reached via the exit transition.

Decomposition:
- Package voice_sched_pkg: NOTE_W/DUR_W defaults, state enum (RUN, WAIT_ADV), helper for slice offsets.
- Sub-module voice_select: parameterised lowest-index-zero priority encoder. Inputs busy[NUM_VOICES]; outputs sel index and any_free.
- Remaining logic, in the top: the FSM, beat countdown and per-voice registers.

Test Plan:
1. Reset mid-activity: assert reset=0 after two loads and mid-advance -> all outputs 0 immediately; after release, evt_ready=1 with enable=1 and evt_is_advance=1.
2. Three notes back-to-back (notes 5, 9, 12, duration 4), all voices idle -> voice_load = 001, 010, 100 in consecutive cycles after each handshake; voice_busy=111; all_busy=1.
3. Fourth note 20 while all busy -> evt_ready=0 until voice_done=010 pulses. One cycle later evt_ready=1, and the next cycle gives voice_load=010 with voice_note slot1=20.
4. Advance of duration 3 with beats every 8 cycles -> advancing=1 and adv_remaining=3,2,1,0 on successive beats. evt_ready rises the cycle after the third beat; a beat arriving with enable=0 does not decrement.
5. Zero-duration note and zero-duration advance -> each consumed in one cycle, no voice_load, state stays RUN.
6. flush during WAIT_ADV (adv_remaining=5) with voice_busy=101 and a coincident voice_done=001 -> next cycle voice_busy=000, adv_remaining=0, advancing=0, no voice_load.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: default widths, the scheduler
// state encoding and a helper that locates a voice's slot in packed buses.
package voice_sched_pkg;

    localparam int unsigned NumVoicesDefault = 3;
    localparam int unsigned NoteWDefault     = 6;
    localparam int unsigned DurWDefault      = 6;

    typedef enum logic [0:0] {
        StRun,
        StWaitAdv
    } sched_state_e;

    // LSB position of voice idx inside a bus packed as idx*width.
    function automatic int unsigned slice_lsb(input int unsigned idx,
                                              input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Event stream from the song reader into the voice scheduler.
//   master: producer, drives valid and the event fields, observes ready
//   slave : scheduler, observes the event, drives ready
// An event transfers on any clock edge where evt_valid & evt_ready.
interface voice_scheduler_if
    import voice_sched_pkg::*;
#(
    parameter int unsigned NoteW = NoteWDefault,
    parameter int unsigned DurW  = DurWDefault
);
    logic             evt_valid;
    logic             evt_ready;
    logic             evt_is_advance;
    logic [NoteW-1:0] evt_note;
    logic [DurW-1:0]  evt_duration;

    modport master (
        output evt_valid,
        output evt_is_advance,
        output evt_note,
        output evt_duration,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_is_advance,
        input  evt_note,
        input  evt_duration,
        output evt_ready
    );
endinterface

// File: rtl/voice_scheduler_select.sv
// Lowest-index-idle priority encoder.
//   busy_i     : per-voice busy mask
//   sel_o      : index of the lowest voice with busy_i == 0 (0 when none free)
//   any_free_o : at least one voice is idle
module voice_select #(
    parameter int unsigned NumVoices = 3,
    localparam int unsigned SelW     = (NumVoices > 1) ? $clog2(NumVoices) : 1
) (
    input  logic [NumVoices-1:0] busy_i,
    output logic [SelW-1:0]      sel_o,
    output logic                 any_free_o
);

    always_comb begin
        sel_o      = '0;
        any_free_o = 1'b0;
        for (int unsigned i = 0; i < NumVoices; i++) begin
            if (!busy_i[i] && !any_free_o) begin
                sel_o      = SelW'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler: consumes note/advance events and hands each note to the
// lowest-index idle note player; advance events hold the stream for a number
// of beats.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   enable_i          : 0 pauses scheduling and beat counting
//   flush_i           : synchronous clear of scheduler state
//   beat_i            : one-cycle beat strobe
//   evt               : event stream (slave side)
//   voice_done_i      : per-voice done pulse from note players
//   voice_load_o      : one-cycle load strobe per voice
//   voice_note_o      : per-voice note, voice i at [i*NoteW +: NoteW]
//   voice_duration_o  : per-voice duration, same packing
//   voice_busy_o      : registered busy mask
//   all_busy_o        : every voice busy
//   advancing_o       : counting down an advance
//   adv_remaining_o   : beats left in the current advance
module voice_scheduler
    import voice_sched_pkg::*;
#(
    parameter int unsigned NumVoices = NumVoicesDefault,
    parameter int unsigned NoteW     = NoteWDefault,
    parameter int unsigned DurW      = DurWDefault
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
    input  logic                       flush_i,
    input  logic                       beat_i,
    voice_scheduler_if.slave           evt,
    input  logic [NumVoices-1:0]       voice_done_i,
    output logic [NumVoices-1:0]       voice_load_o,
    output logic [NumVoices*NoteW-1:0] voice_note_o,
    output logic [NumVoices*DurW-1:0]  voice_duration_o,
    output logic [NumVoices-1:0]       voice_busy_o,
    output logic                       all_busy_o,
    output logic                       advancing_o,
    output logic [DurW-1:0]            adv_remaining_o
);

    localparam int unsigned SelW = (NumVoices > 1) ? $clog2(NumVoices) : 1;

    sched_state_e               state_q;
    logic [NumVoices-1:0]       busy_q;
    logic [NumVoices-1:0]       load_q;
    logic [NumVoices*NoteW-1:0] note_q;
    logic [NumVoices*DurW-1:0]  dur_q;
    logic [DurW-1:0]            adv_q;

    logic [SelW-1:0] sel;
    logic            any_free;
    logic            handshake;
    logic            dur_nonzero;

    voice_select #(
        .NumVoices (NumVoices)
    ) u_select (
        .busy_i     (busy_q),
        .sel_o      (sel),
        .any_free_o (any_free)
    );

    // Advances never need a voice, so only notes stall on a full house.
    assign evt.evt_ready = enable_i & ~flush_i & (state_q == StRun)
                         & (evt.evt_is_advance | any_free);
    assign handshake     = evt.evt_valid & evt.evt_ready;
    assign dur_nonzero   = (evt.evt_duration != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StRun;
            busy_q  <= '0;
            load_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            adv_q   <= '0;
        end else begin
            load_q <= '0;
            if (flush_i) begin
                state_q <= StRun;
                busy_q  <= '0;
                adv_q   <= '0;
            end else begin
                // Done is honoured even while paused so players can finish.
                busy_q <= busy_q & ~voice_done_i;
                unique case (state_q)
                    StRun: begin
                        if (handshake && dur_nonzero) begin
                            if (evt.evt_is_advance) begin
                                adv_q   <= evt.evt_duration;
                                state_q <= StWaitAdv;
                            end else begin
                                // Done never targets the freshly selected voice,
                                // so this bit override cannot lose a clear.
                                busy_q[sel] <= 1'b1;
                                load_q[sel] <= 1'b1;
                                note_q[slice_lsb(32'(sel), NoteW) +: NoteW] <= evt.evt_note;
                                dur_q[slice_lsb(32'(sel), DurW) +: DurW]    <= evt.evt_duration;
                            end
                        end
                    end
                    StWaitAdv: begin
                        // adv_q is at least 1 here, so the decrement cannot wrap.
                        if (enable_i && beat_i) begin
                            adv_q <= adv_q - DurW'(1);
                            if (adv_q == DurW'(1)) begin
                                state_q <= StRun;
                            end
                        end
                    end
                    default: state_q <= StRun;
                endcase
            end
        end
    end

    assign voice_load_o     = load_q;
    assign voice_note_o     = note_q;
    assign voice_duration_o = dur_q;
    assign voice_busy_o     = busy_q;
    assign all_busy_o       = ~any_free;
    assign advancing_o      = (state_q == StWaitAdv);
    assign adv_remaining_o  = adv_q;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

    localparam int unsigned NumVoices = 3;
    localparam int unsigned NoteW     = 6;
    localparam int unsigned DurW      = 6;

    logic                       clk;
    logic                       rst_n;
    logic                       enable;
    logic                       flush;
    logic                       beat;
    logic [NumVoices-1:0]       voice_done;
    logic [NumVoices-1:0]       voice_load;
    logic [NumVoices*NoteW-1:0] voice_note;
    logic [NumVoices*DurW-1:0]  voice_duration;
    logic [NumVoices-1:0]       voice_busy;
    logic                       all_busy;
    logic                       advancing;
    logic [DurW-1:0]            adv_remaining;

    int n_checks = 0;
    int n_pass   = 0;

    voice_scheduler_if #(.NoteW(NoteW), .DurW(DurW)) evt_if ();

    voice_scheduler #(
        .NumVoices (NumVoices),
        .NoteW     (NoteW),
        .DurW      (DurW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .flush_i          (flush),
        .beat_i           (beat),
        .evt              (evt_if),
        .voice_done_i     (voice_done),
        .voice_load_o     (voice_load),
        .voice_note_o     (voice_note),
        .voice_duration_o (voice_duration),
        .voice_busy_o     (voice_busy),
        .all_busy_o       (all_busy),
        .advancing_o      (advancing),
        .adv_remaining_o  (adv_remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_evt(input logic valid, input logic adv, input logic [NoteW-1:0] note,
                           input logic [DurW-1:0] dur);
        evt_if.evt_valid      = valid;
        evt_if.evt_is_advance = adv;
        evt_if.evt_note       = note;
        evt_if.evt_duration   = dur;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1; flush = 1'b0; beat = 1'b0; voice_done = '0;
        put_evt(1'b0, 1'b1, '0, '0);
        repeat (3) tick();
        n_checks++;
        if ({voice_load, voice_busy, adv_remaining, advancing} !== '0)
            $display("FAIL reset_regs got load=%b busy=%b adv=%0d advancing=%b want all 0",
                     voice_load, voice_busy, adv_remaining, advancing);
        else n_pass++;
        n_checks++;
        if ({voice_note, voice_duration} !== '0)
            $display("FAIL reset_slots got note=%h dur=%h want 0", voice_note, voice_duration);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (evt_if.evt_ready !== 1'b1)
            $display("FAIL reset_ready got %b want 1", evt_if.evt_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [NumVoices-1:0] exp_load;
        logic [NoteW-1:0]     notes [3];
        notes[0] = 6'd5; notes[1] = 6'd9; notes[2] = 6'd12;
        for (int i = 0; i < 3; i++) begin
            put_evt(1'b1, 1'b0, notes[i], 6'd4);
            #1;
            n_checks++;
            if (evt_if.evt_ready !== 1'b1)
                $display("FAIL b2b_ready%0d got %b want 1", i, evt_if.evt_ready);
            else n_pass++;
            tick();
            exp_load = 3'b001 << i;
            n_checks++;
            if (voice_load !== exp_load)
                $display("FAIL b2b_load%0d got %b want %b", i, voice_load, exp_load);
            else n_pass++;
        end
        put_evt(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (voice_busy !== 3'b111 || all_busy !== 1'b1)
            $display("FAIL b2b_busy got busy=%b all=%b want 111/1", voice_busy, all_busy);
        else n_pass++;
        n_checks++;
        if (voice_note !== {6'd12, 6'd9, 6'd5} || voice_duration !== {6'd4, 6'd4, 6'd4})
            $display("FAIL b2b_slots got note=%h dur=%h want %h/%h", voice_note,
                     voice_duration, {6'd12, 6'd9, 6'd5}, {6'd4, 6'd4, 6'd4});
        else n_pass++;
        tick();
        n_checks++;
        if (voice_load !== 3'b000)
            $display("FAIL b2b_load_pulse got %b want 000", voice_load);
        else n_pass++;
    endtask

    task automatic test_stall();
        put_evt(1'b1, 1'b0, 6'd20, 6'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (evt_if.evt_ready !== 1'b0 || voice_load !== 3'b000)
                $display("FAIL stall_hold%0d got ready=%b load=%b want 0/000", i,
                         evt_if.evt_ready, voice_load);
            else n_pass++;
            tick();
        end
        voice_done = 3'b010;
        tick();
        voice_done = 3'b000;
        n_checks++;
        if (evt_if.evt_ready !== 1'b1 || voice_busy !== 3'b101)
            $display("FAIL stall_freed got ready=%b busy=%b want 1/101",
                     evt_if.evt_ready, voice_busy);
        else n_pass++;
        tick();
        put_evt(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (voice_load !== 3'b010 || voice_note[11:6] !== 6'd20)
            $display("FAIL stall_reload got load=%b slot1=%0d want 010/20",
                     voice_load, voice_note[11:6]);
        else n_pass++;
        voice_done = 3'b111;
        tick();
        voice_done = 3'b000;
        n_checks++;
        if (voice_busy !== 3'b000)
            $display("FAIL stall_clear got %b want 000", voice_busy);
        else n_pass++;
    endtask

    task automatic test_advance();
        put_evt(1'b1, 1'b1, '0, 6'd3);
        tick();
        put_evt(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (advancing !== 1'b1 || adv_remaining !== 6'd3 || evt_if.evt_ready !== 1'b0)
            $display("FAIL adv_start got adv=%b rem=%0d ready=%b want 1/3/0",
                     advancing, adv_remaining, evt_if.evt_ready);
        else n_pass++;
        // Beat 1
        repeat (7) tick();
        beat = 1'b1; tick(); beat = 1'b0;
        n_checks++;
        if (adv_remaining !== 6'd2)
            $display("FAIL adv_beat1 got %0d want 2", adv_remaining);
        else n_pass++;
        // Beat while paused must not count
        repeat (7) tick();
        enable = 1'b0; beat = 1'b1; tick(); beat = 1'b0; enable = 1'b1;
        n_checks++;
        if (adv_remaining !== 6'd2 || advancing !== 1'b1)
            $display("FAIL adv_paused got rem=%0d adv=%b want 2/1", adv_remaining, advancing);
        else n_pass++;
        repeat (7) tick();
        beat = 1'b1; tick(); beat = 1'b0;
        n_checks++;
        if (adv_remaining !== 6'd1 || evt_if.evt_ready !== 1'b0)
            $display("FAIL adv_beat2 got rem=%0d ready=%b want 1/0",
                     adv_remaining, evt_if.evt_ready);
        else n_pass++;
        repeat (7) tick();
        beat = 1'b1; tick(); beat = 1'b0;
        n_checks++;
        if (adv_remaining !== 6'd0 || advancing !== 1'b0 || evt_if.evt_ready !== 1'b1)
            $display("FAIL adv_exit got rem=%0d adv=%b ready=%b want 0/0/1",
                     adv_remaining, advancing, evt_if.evt_ready);
        else n_pass++;
    endtask

    task automatic test_zero_duration();
        put_evt(1'b1, 1'b0, 6'd7, 6'd0);
        tick();
        n_checks++;
        if (voice_load !== 3'b000 || voice_busy !== 3'b000 || advancing !== 1'b0)
            $display("FAIL zero_note got load=%b busy=%b adv=%b want 000/000/0",
                     voice_load, voice_busy, advancing);
        else n_pass++;
        put_evt(1'b1, 1'b1, '0, 6'd0);
        tick();
        n_checks++;
        if (advancing !== 1'b0 || adv_remaining !== 6'd0 || evt_if.evt_ready !== 1'b1
            || voice_load !== 3'b000)
            $display("FAIL zero_adv got adv=%b rem=%0d ready=%b load=%b want 0/0/1/000",
                     advancing, adv_remaining, evt_if.evt_ready, voice_load);
        else n_pass++;
        put_evt(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            put_evt(1'b1, 1'b0, 6'(i + 1), 6'd4);
            tick();
        end
        put_evt(1'b0, 1'b0, '0, '0);
        voice_done = 3'b010; tick(); voice_done = 3'b000;
        put_evt(1'b1, 1'b1, '0, 6'd5);
        tick();
        put_evt(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (voice_busy !== 3'b101 || adv_remaining !== 6'd5 || advancing !== 1'b1)
            $display("FAIL flush_setup got busy=%b rem=%0d adv=%b want 101/5/1",
                     voice_busy, adv_remaining, advancing);
        else n_pass++;
        flush = 1'b1; voice_done = 3'b001; beat = 1'b1;
        put_evt(1'b1, 1'b1, '0, 6'd2);
        #1;
        n_checks++;
        if (evt_if.evt_ready !== 1'b0)
            $display("FAIL flush_ready got %b want 0", evt_if.evt_ready);
        else n_pass++;
        tick();
        flush = 1'b0; voice_done = 3'b000; beat = 1'b0;
        put_evt(1'b0, 1'b0, '0, '0);
        n_checks++;
        if (voice_busy !== 3'b000 || adv_remaining !== 6'd0 || advancing !== 1'b0
            || voice_load !== 3'b000)
            $display("FAIL flush_clear got busy=%b rem=%0d adv=%b load=%b want 000/0/0/000",
                     voice_busy, adv_remaining, advancing, voice_load);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        put_evt(1'b1, 1'b0, 6'd7, 6'd3); tick();
        put_evt(1'b1, 1'b0, 6'd8, 6'd3); tick();
        put_evt(1'b1, 1'b1, '0, 6'd4); tick();
        put_evt(1'b0, 1'b0, '0, '0);
        beat = 1'b1; tick(); beat = 1'b0;
        n_checks++;
        if (adv_remaining !== 6'd3 || voice_busy !== 3'b011)
            $display("FAIL rstmid_setup got rem=%0d busy=%b want 3/011",
                     adv_remaining, voice_busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({voice_load, voice_busy, adv_remaining, advancing, all_busy} !== '0
            || {voice_note, voice_duration} !== '0)
            $display("FAIL rstmid_async got load=%b busy=%b rem=%0d adv=%b note=%h dur=%h want 0",
                     voice_load, voice_busy, adv_remaining, advancing, voice_note,
                     voice_duration);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        enable = 1'b1;
        put_evt(1'b0, 1'b1, '0, '0);
        #1;
        n_checks++;
        if (evt_if.evt_ready !== 1'b1)
            $display("FAIL rstmid_ready got %b want 1", evt_if.evt_ready);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_advance();
        test_zero_duration();
        test_flush();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
